card_dealer: RTL and testbench
==============================

# card_dealer

Card source for the BlackJack datapath and the producer side of the hand add-card interface. On a deal request it draws a pseudo-random rank from a single 52-card deck and emits the card value with a one-cycle strobe aimed at either the player or the dealer hand. It sits between the game FSM, which issues requests, and the two hand controllers, which consume `card` values on an add-card strobe.

## Interface
Parameters:
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- `i_clk`  in  1  system clock; all state is updated on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_dealReq`  in  1  deal request; accepted when `i_dealReq && o_ready`.
- `i_target`  in  1  destination, sampled at acceptance: 0 = player, 1 = dealer.
- `i_shuffle`  in  1  refill the deck to 52 cards; honoured only in IDLE.
- `o_ready`  out  1  high in IDLE when the deck is not empty.
- `o_card`  out  5  `card` value: 2–10, face cards = 10, ace = 11. Held until the next issue.
- `o_rank`  out  4  rank 1–13 (ace = 1, K = 13), for display. Held with `o_card`.
- `o_addPlayer`  out  1  one-cycle add-card strobe to the player hand.
- `o_addDealer`  out  1  one-cycle add-card strobe to the dealer hand.
- `o_cardsRemaining`  out  6  number of cards left in the deck, 0–52.
- `o_emptyErr`  out  1  one-cycle pulse when a request arrives in IDLE with an empty deck.

## Operation
- **LFSR:** 16-bit Galois, free-running every cycle in every state.
  - next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0).
- **Deck state:**
  - Per-rank count `cnt[0..12]`, 3 bits each; reset and shuffle set every entry to 4.
  - `o_cardsRemaining` equals the sum of the counts and is kept as its own down-counter.
- **FSM states:** IDLE, DRAW, ISSUE.
  - IDLE, `i_shuffle`=1: refill the deck and stay in IDLE. Any `i_dealReq` in the same cycle is dropped with no error.
  - IDLE, request accepted: latch `i_target`, go to DRAW.
  - IDLE, `i_dealReq` with deck empty and no shuffle: pulse `o_emptyErr` the next cycle and stay in IDLE.
  - DRAW: candidate = lfsr[3:0]. If candidate < 13 and `cnt[candidate]` != 0, register rank = candidate+1 and its value, then go to ISSUE. Otherwise stay in DRAW; the LFSR advances and the draw is retried.
  - ISSUE: assert the strobe selected by the latched target for exactly one cycle. Update `o_card`/`o_rank` that cycle, decrement `cnt` and `o_cardsRemaining`, then go to IDLE.
- **Ignored inputs:** `i_shuffle` and `i_dealReq` are ignored in DRAW and ISSUE. Callers wait for `o_ready`.
- **Strobe exclusivity:** `o_addPlayer` and `o_addDealer` are never high together.
- **Reset values** (apply at any time, including mid-DRAW or mid-ISSUE):
  - FSM = IDLE; `o_card` = 0; `o_rank` = 0; both strobes 0; `o_emptyErr` = 0.
  - `o_cardsRemaining` = 52; all `cnt` = 4; LFSR = `SEED`; `o_ready` = 1.
  - A strobe pending at the moment of reset is never emitted.

## Timing
- Request accepted at edge T: DRAW during T+1.
- Minimum latency: strobe high during cycle T+2 (first draw hits). Each rejected draw adds one cycle.
- `o_card`/`o_rank` are valid in the same cycle as the strobe and remain stable afterwards.
- `o_cardsRemaining` decrements at the end of the ISSUE cycle.
- `o_ready` is low from T+1 until IDLE is re-entered, at T+3 minimum.
- Back-to-back deals: at most one card per 3 cycles.
- Shuffle takes effect at the next edge; `o_cardsRemaining` reads 52 the following cycle.
- All outputs are registered; none has a combinational path from any input.

## Configuration
- **`DEALER_DECK_TRACK_EN` defined:** finite 52-card deck exactly as described above.
- **`DEALER_DECK_TRACK_EN` undefined** (infinite shoe):
  - `cnt` storage is removed; a candidate is accepted whenever it is < 13.
  - `o_cardsRemaining` is tied to 52; `o_emptyErr` is tied to 0.
  - `o_ready` is high whenever the FSM is in IDLE; `i_shuffle` has no effect.

## Structure
- `card.svh` / shared package holds:
  - the `card` width (5);
  - constants `NUM_RANKS`=13, `DECK_SIZE`=52, `CARDS_PER_RANK`=4, `LFSR_TAPS`=16'hB400;
  - the rank-to-value function, shared with the hand controllers.
- Sub-module `card_lfsr`: parameter `SEED`, ports `i_clk`, `i_reset_n`, `o_state[15:0]`.
- FSM and deck counts live in `card_dealer`.

## Test plan
- **Reset:** drive `i_reset_n`=0 → `o_ready`=1, `o_cardsRemaining`=52, both strobes 0, `o_card`=0.
- **Single deal:** one request with `i_target`=1 → exactly one `o_addDealer` pulse, no `o_addPlayer`. Strobe no earlier than T+2; `o_card` ∈ {2..11} and consistent with `o_rank`; `o_cardsRemaining`=51.
- **Full deck:** 52 consecutive deals (alternating targets) → each rank seen exactly 4 times; `o_card` values sum to 380; `o_cardsRemaining`=0; `o_ready`=0.
- **Empty then shuffle:** 53rd request → `o_emptyErr` pulses once, no strobe. `i_shuffle` with `i_dealReq` in the same cycle → request dropped, `o_cardsRemaining`=52, next request deals normally.
- **Reset mid-operation:** assert `i_reset_n`=0 during DRAW → no strobe ever emitted for that request; all reset values restored.
- **Infinite shoe:** with `DEALER_DECK_TRACK_EN` undefined, 60 deals → 60 strobes, `o_cardsRemaining` stays 52, no `o_emptyErr`.

Source files
------------

// File: rtl/card_dealer_pkg.sv
// Shared card constants, dealer FSM states and the rank-to-value mapping
// used by both the dealer and the hand controllers.
package card_dealer_pkg;

    localparam int CARD_W         = 5;
    localparam int NUM_RANKS      = 13;
    localparam int DECK_SIZE      = 52;
    localparam int CARDS_PER_RANK = 4;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_ISSUE
    } dealState_t;

    // Ace counts high (11); ten and the face cards (ranks 10..13) count as 10.
    function automatic card_t rankToValue(input logic [3:0] rank);
        card_t value;
        if (rank == 4'd1) begin
            value = card_t'(11);
        end else if (rank >= 4'd10) begin
            value = card_t'(10);
        end else begin
            value = card_t'(rank);
        end
        return value;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every cycle, no stall input.
// A zero SEED would lock the register at zero, so it is replaced by DEFAULT_SEED.
module card_lfsr
    import card_dealer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic [15:0] o_state
);

    localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_state <= RESET_VAL;
        end else begin
            o_state <= {1'b0, o_state[15:1]} ^ (o_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: request -> strobe after >= 2 cycles (one more per rejected draw), 1 card per 3 cycles max.
// Backpressure via o_ready (low while busy or deck empty). DEALER_DECK_TRACK_EN selects finite deck vs infinite shoe.
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_dealReq,
    input  logic              i_target,
    input  logic              i_shuffle,
    output logic              o_ready,
    output logic [CARD_W-1:0] o_card,
    output logic [3:0]        o_rank,
    output logic              o_addPlayer,
    output logic              o_addDealer,
    output logic [5:0]        o_cardsRemaining,
    output logic              o_emptyErr
);

    dealState_t state, stateNext;
    logic [15:0] lfsr;
    logic [3:0]  candidate;
    logic [15:0] availPad;
    logic [NUM_RANKS-1:0] avail;
    logic hit, accept, issueDone, readyNext, targetQ;
    logic unusedBits;

    card_lfsr #(.SEED(SEED)) uLfsr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_state   (lfsr)
    );

    assign candidate  = lfsr[3:0];
    assign unusedBits = &{1'b0, lfsr[15:4], i_shuffle};

`ifdef DEALER_DECK_TRACK_EN
    logic [2:0] cnt [NUM_RANKS];
    logic       shuffleNow, emptyReq;
    logic [5:0] remNext;

    always_comb begin
        for (int r = 0; r < NUM_RANKS; r++) begin
            avail[r] = (cnt[r] != 3'd0);
        end
    end
`else
    assign avail = '1;
`endif

    // Candidates 13..15 land on the zero padding and are rejected like empty ranks.
    assign availPad = {{(16 - NUM_RANKS){1'b0}}, avail};

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        hit       = 1'b0;
        issueDone = 1'b0;
`ifdef DEALER_DECK_TRACK_EN
        shuffleNow = 1'b0;
        emptyReq   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
`ifdef DEALER_DECK_TRACK_EN
                if (i_shuffle) begin
                    shuffleNow = 1'b1;
                end else if (i_dealReq) begin
                    if (o_ready) begin
                        accept = 1'b1;
                    end else begin
                        emptyReq = 1'b1;
                    end
                end
`else
                accept = i_dealReq;
`endif
                if (accept) begin
                    stateNext = ST_DRAW;
                end
            end
            ST_DRAW: begin
                hit = availPad[candidate];
                if (hit) begin
                    stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issueDone = 1'b1;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase

`ifdef DEALER_DECK_TRACK_EN
        remNext = o_cardsRemaining;
        if (shuffleNow) begin
            remNext = 6'(DECK_SIZE);
        end else if (issueDone) begin
            remNext = o_cardsRemaining - 6'd1;
        end
        readyNext = (stateNext == ST_IDLE) && (remNext != 6'd0);
`else
        readyNext = (stateNext == ST_IDLE);
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            targetQ     <= 1'b0;
            o_ready     <= 1'b1;
            o_card      <= '0;
            o_rank      <= '0;
            o_addPlayer <= 1'b0;
            o_addDealer <= 1'b0;
        end else begin
            state       <= stateNext;
            o_ready     <= readyNext;
            o_addPlayer <= hit && !targetQ;
            o_addDealer <= hit && targetQ;
            if (accept) begin
                targetQ <= i_target;
            end
            if (hit) begin
                o_rank <= candidate + 4'd1;
                o_card <= rankToValue(candidate + 4'd1);
            end
        end
    end

`ifdef DEALER_DECK_TRACK_EN
    // o_rank still holds the card being issued during ISSUE, so it picks the count to decrement.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt[r] <= 3'(CARDS_PER_RANK);
            end
            o_cardsRemaining <= 6'(DECK_SIZE);
            o_emptyErr       <= 1'b0;
        end else begin
            o_emptyErr       <= emptyReq;
            o_cardsRemaining <= remNext;
            for (int r = 0; r < NUM_RANKS; r++) begin
                if (shuffleNow) begin
                    cnt[r] <= 3'(CARDS_PER_RANK);
                end else if (issueDone && (o_rank == 4'(r + 1))) begin
                    cnt[r] <= cnt[r] - 3'd1;
                end
            end
        end
    end
`else
    assign o_cardsRemaining = 6'(DECK_SIZE);
    assign o_emptyErr       = 1'b0;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: predicts every dealt rank and its latency from a reference LFSR.
module tb_card_dealer;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       i_reset_n, i_dealReq, i_target, i_shuffle;
    logic       o_ready, o_addPlayer, o_addDealer, o_emptyErr;
    logic [4:0] o_card;
    logic [3:0] o_rank;
    logic [5:0] o_cardsRemaining;

    card_dealer #(.SEED(16'hACE1)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_dealReq        (i_dealReq),
        .i_target         (i_target),
        .i_shuffle        (i_shuffle),
        .o_ready          (o_ready),
        .o_card           (o_card),
        .o_rank           (o_rank),
        .o_addPlayer      (o_addPlayer),
        .o_addDealer      (o_addDealer),
        .o_cardsRemaining (o_cardsRemaining),
        .o_emptyErr       (o_emptyErr)
    );

`ifdef DEALER_DECK_TRACK_EN
    localparam bit FINITE = 1'b1;
`else
    localparam bit FINITE = 1'b0;
`endif

    typedef struct {
        logic [3:0] rank;
        logic       tgt;
        int         cyc;
        int         remAtStrobe;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    logic [15:0] mLfsr;
    int          mCnt[13];
    int          mRem;
    int          hist[13];
    int          cardSum;
    int          nPlayer = 0, nDealer = 0, nBoth = 0, nErr = 0;

    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [4:0] valueOf(input logic [3:0] r);
        if (r == 4'd1) return 5'd11;
        if (r >= 4'd10) return 5'd10;
        return {1'b0, r};
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) mLfsr <= 16'hACE1;
        else            mLfsr <= lfsrStep(mLfsr);
    end

    always @(negedge i_clk) begin
        if (o_addPlayer) nPlayer++;
        if (o_addDealer) nDealer++;
        if (o_addPlayer && o_addDealer) nBoth++;
        if (o_emptyErr) nErr++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic modelRefill();
        for (int i = 0; i < 13; i++) mCnt[i] = 4;
        mRem = 52;
    endtask

    task automatic clearHist();
        for (int i = 0; i < 13; i++) hist[i] = 0;
        cardSum = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the deal completes.
    task automatic doDeal(input logic tgt, input logic withShuffle);
        logic [15:0] l;
        int   j, n, c;
        exp_t e, got;
        total++;
        if (o_ready !== 1'b1) begin
            $display("FAIL ready_before_deal: got %b want 1", o_ready); bad++;
        end
        l = mLfsr; j = 0; c = 0;
        while (j < 70000) begin
            j++;
            l = lfsrStep(l);
            c = int'(l[3:0]);
            if (c < 13) begin
                if (!FINITE) break;
                if (mCnt[c] > 0) break;
            end
        end
        e.rank = 4'(c + 1); e.tgt = tgt; e.cyc = j + 1; e.remAtStrobe = mRem;
        if (FINITE) begin mCnt[c]--; mRem--; end
        sb.push_back(e);
        i_dealReq = 1'b1; i_target = tgt; i_shuffle = withShuffle;
        @(negedge i_clk);
        i_dealReq = 1'b0; i_shuffle = 1'b0; i_target = ~tgt;
        n = 1;
        while (!(o_addPlayer || o_addDealer) && n < 3000) begin
            @(negedge i_clk); n++;
        end
        got = sb.pop_front();
        total++;
        if (!(o_addPlayer || o_addDealer)) begin
            $display("FAIL strobe_timeout: no strobe after %0d cycles, wanted rank %0d", n, got.rank); bad++;
        end else begin
            total++;
            if (n !== got.cyc) begin $display("FAIL latency: got %0d cycles want %0d", n, got.cyc); bad++; end
            total++;
            if (o_rank !== got.rank) begin $display("FAIL rank: got %0d want %0d", o_rank, got.rank); bad++; end
            total++;
            if (o_card !== valueOf(got.rank)) begin $display("FAIL card: got %0d want %0d", o_card, valueOf(got.rank)); bad++; end
            total++;
            if (o_addDealer !== got.tgt) begin $display("FAIL dealer_strobe: got %b want %b", o_addDealer, got.tgt); bad++; end
            total++;
            if (o_addPlayer !== !got.tgt) begin $display("FAIL player_strobe: got %b want %b", o_addPlayer, !got.tgt); bad++; end
            total++;
            if (o_cardsRemaining !== 6'(got.remAtStrobe)) begin
                $display("FAIL remaining_at_strobe: got %0d want %0d", o_cardsRemaining, got.remAtStrobe); bad++;
            end
            hist[got.rank - 1]++;
            cardSum += int'(valueOf(got.rank));
            @(negedge i_clk);
            total++;
            if (o_addPlayer || o_addDealer) begin
                $display("FAIL strobe_width: got P=%b D=%b want 0 0", o_addPlayer, o_addDealer); bad++;
            end
            total++;
            if (o_card !== valueOf(got.rank) || o_rank !== got.rank) begin
                $display("FAIL card_hold: got card %0d rank %0d want %0d %0d", o_card, o_rank, valueOf(got.rank), got.rank); bad++;
            end
            total++;
            if (o_cardsRemaining !== 6'(mRem)) begin
                $display("FAIL remaining_after: got %0d want %0d", o_cardsRemaining, mRem); bad++;
            end
            total++;
            if (o_ready !== (mRem != 0)) begin
                $display("FAIL ready_after: got %b want %b", o_ready, (mRem != 0)); bad++;
            end
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_dealReq = 1'b0; i_target = 1'b0; i_shuffle = 1'b0;
        modelRefill();
        repeat (3) @(negedge i_clk);
        total++;
        if (o_ready !== 1'b1 || o_cardsRemaining !== 6'd52) begin
            $display("FAIL reset_ready_rem: got ready %b rem %0d want 1 52", o_ready, o_cardsRemaining); bad++;
        end
        total++;
        if (o_addPlayer !== 1'b0 || o_addDealer !== 1'b0 || o_emptyErr !== 1'b0) begin
            $display("FAIL reset_pulses: got P=%b D=%b E=%b want 0 0 0", o_addPlayer, o_addDealer, o_emptyErr); bad++;
        end
        total++;
        if (o_card !== 5'd0 || o_rank !== 4'd0) begin
            $display("FAIL reset_card: got card %0d rank %0d want 0 0", o_card, o_rank); bad++;
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b1) begin $display("FAIL ready_post_reset: got %b want 1", o_ready); bad++; end
    endtask

    task automatic test_single_deal();
        int p0, d0;
        clearHist();
        p0 = nPlayer; d0 = nDealer;
        doDeal(1'b1, 1'b0);
        total++;
        if (nDealer !== d0 + 1 || nPlayer !== p0) begin
            $display("FAIL single_deal_pulses: got dealer %0d player %0d want 1 0", nDealer - d0, nPlayer - p0); bad++;
        end
    endtask

    task automatic test_full_deck();
        for (int i = 0; i < 51; i++) doDeal(i[0], 1'b0);
        for (int r = 0; r < 13; r++) begin
            total++;
            if (hist[r] !== 4) begin $display("FAIL rank_hist_%0d: got %0d want 4", r + 1, hist[r]); bad++; end
        end
        total++;
        if (cardSum !== 380) begin $display("FAIL deck_sum: got %0d want 380", cardSum); bad++; end
        total++;
        if (o_cardsRemaining !== 6'd0 || o_ready !== 1'b0) begin
            $display("FAIL deck_empty: got rem %0d ready %b want 0 0", o_cardsRemaining, o_ready); bad++;
        end
    endtask

    task automatic test_empty_shuffle();
        int p0, d0, e0;
        p0 = nPlayer; d0 = nDealer; e0 = nErr;
        i_dealReq = 1'b1;
        @(negedge i_clk);
        i_dealReq = 1'b0;
        total++;
        if (o_emptyErr !== 1'b1) begin $display("FAIL empty_err_pulse: got %b want 1", o_emptyErr); bad++; end
        @(negedge i_clk);
        total++;
        if (o_emptyErr !== 1'b0) begin $display("FAIL empty_err_width: got %b want 0", o_emptyErr); bad++; end
        repeat (4) @(negedge i_clk);
        total++;
        if (nErr !== e0 + 1 || nPlayer !== p0 || nDealer !== d0) begin
            $display("FAIL empty_counts: got err %0d strobes %0d want 1 0", nErr - e0, nPlayer - p0 + nDealer - d0); bad++;
        end
        i_shuffle = 1'b1; i_dealReq = 1'b1; i_target = 1'b1;
        @(negedge i_clk);
        i_shuffle = 1'b0; i_dealReq = 1'b0;
        modelRefill();
        total++;
        if (o_cardsRemaining !== 6'd52 || o_ready !== 1'b1) begin
            $display("FAIL shuffle_refill: got rem %0d ready %b want 52 1", o_cardsRemaining, o_ready); bad++;
        end
        repeat (6) @(negedge i_clk);
        total++;
        if (nPlayer !== p0 || nDealer !== d0) begin
            $display("FAIL shuffle_drop: got %0d strobes want 0", nPlayer - p0 + nDealer - d0); bad++;
        end
        doDeal(1'b0, 1'b0);
    endtask

    task automatic test_infinite_shoe();
        int p0, d0, e0;
        p0 = nPlayer; d0 = nDealer; e0 = nErr;
        for (int i = 0; i < 60; i++) doDeal(i[0], 1'b0);
        total++;
        if (nPlayer + nDealer !== p0 + d0 + 60) begin
            $display("FAIL shoe_strobes: got %0d want 60", nPlayer + nDealer - p0 - d0); bad++;
        end
        total++;
        if (nErr !== e0 || o_cardsRemaining !== 6'd52) begin
            $display("FAIL shoe_state: got err %0d rem %0d want 0 52", nErr - e0, o_cardsRemaining); bad++;
        end
        doDeal(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_draw();
        int p0, d0;
        p0 = nPlayer; d0 = nDealer;
        total++;
        if (o_ready !== 1'b1) begin $display("FAIL ready_before_reset_deal: got %b want 1", o_ready); bad++; end
        i_dealReq = 1'b1; i_target = 1'b0;
        @(negedge i_clk);
        i_dealReq = 1'b0;
        i_reset_n = 1'b0;
        modelRefill();
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b1 || o_cardsRemaining !== 6'd52 || o_card !== 5'd0 || o_rank !== 4'd0) begin
            $display("FAIL mid_reset_values: got ready %b rem %0d card %0d rank %0d want 1 52 0 0",
                     o_ready, o_cardsRemaining, o_card, o_rank); bad++;
        end
        i_reset_n = 1'b1;
        repeat (20) @(negedge i_clk);
        total++;
        if (nPlayer !== p0 || nDealer !== d0) begin
            $display("FAIL mid_reset_strobe: got %0d strobes want 0", nPlayer - p0 + nDealer - d0); bad++;
        end
        doDeal(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_deal();
`ifdef DEALER_DECK_TRACK_EN
        test_full_deck();
        test_empty_shuffle();
`else
        test_infinite_shoe();
`endif
        test_reset_mid_draw();
        total++;
        if (nBoth !== 0) begin $display("FAIL strobe_exclusive: got %0d overlaps want 0", nBoth); bad++; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
